// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and access sequencer for one shared fixed-latency memory port
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   // instruction fetch port
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   // data (load/store) port
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   // pipeline stalls
   output logic              stall_if_o,
   output logic              stall_mem_o,
   // shared memory port
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   // status
   output logic              busy_o
);

   // The wait counter holds MEM_LAT-1 down to 0; keep at least one bit for MEM_LAT=1.
   localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;    // 1 = data port owns the access, 0 = fetch
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   logic              grant_dm;
   logic              grant_if;
   logic              capture;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int              SC_W    = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);

   logic [SC_W-1:0] starve_q, starve_d;
   logic            starve_hit;

   // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
   always_comb begin
      starve_hit = if_req_i && (starve_q == SC_MAX);
      grant_if   = if_req_i && (!dm_req_i || starve_hit);
      grant_dm   = dm_req_i && !grant_if;
      starve_d   = starve_q;
      if (state_q == S_IDLE) begin
         if (grant_if) begin
            starve_d = '0;
         end else if (grant_dm && if_req_i && (starve_q != SC_MAX)) begin
            starve_d = starve_q + SC_W'(1);
         end
      end
   end

   // Saturating count of data grants made over a pending fetch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   localparam int starve_max_unused = STARVE_MAX;

   // Strict data priority: a fetch is granted only when no data request is pending.
   always_comb begin
      grant_dm = dm_req_i;
      grant_if = if_req_i && !dm_req_i;
   end
`endif

   // Next-state and access latch logic for the IDLE/ISSUE/WAIT/ACK sequencer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_dm) begin
               owner_d = 1'b1;
               we_d    = dm_we_i;
               addr_d  = dm_addr_i;
               wdata_d = dm_wdata_i;
               state_d = S_ISSUE;
            end else if (grant_if) begin
               owner_d = 1'b0;
               we_d    = 1'b0;
               addr_d  = if_addr_i;
               wdata_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // With MEM_LAT=1 the counter loads 0, so the single WAIT cycle is the capture cycle.
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ACK: begin
            // Requests are ignored here so a stale request of the acked port is not regranted.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state and latched access descriptor.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Read data is valid in the last WAIT cycle; stores never touch the rdata registers.
   assign capture = (state_q == S_WAIT) && (cnt_q == '0) && !we_q;

   // Capture memory read data into the owning port's result register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (capture) begin
         if (owner_q) begin
            dm_rdata_q <= mem_rdata_i;
         end else begin
            if_rdata_q <= mem_rdata_i;
         end
      end
   end

   // Output decode from registered state.
   always_comb begin
      mem_en_o    = (state_q == S_ISSUE);
      mem_we_o    = (state_q == S_ISSUE) && we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      if_ack_o    = (state_q == S_ACK) && !owner_q;
      dm_ack_o    = (state_q == S_ACK) && owner_q;
      if_rdata_o  = if_rdata_q;
      dm_rdata_o  = dm_rdata_q;
      busy_o      = (state_q != S_IDLE);
      stall_if_o  = if_req_i && !if_ack_o;
      stall_mem_o = dm_req_i && !dm_ack_o;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          if_ack, dm_ack, stall_if, stall_mem, mem_en, mem_we, busy;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory contents seen by the arbiter; writes are sunk and checked at the port.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h40) return 32'h8C22_0004;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Fixed-latency memory: data valid exactly LAT cycles after the issue cycle, junk otherwise.
   logic          pend = 1'b0;
   int            due  = 0;
   logic [31:0]   due_data;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (pend && cyc == due) begin
         mem_rdata = due_data;
         pend      = 1'b0;
      end else begin
         mem_rdata = 32'hBAD0_0000 | 32'(cyc);
      end
   end

   // Issue observation and scoreboards.
   int            en_cnt = 0;
   int            en_cyc = 0;
   logic [31:0]   en_addr, en_wdata;
   logic          en_we, en_busy;
   logic [31:0]   if_sb[$];
   logic [31:0]   dm_sb[$];
   logic [31:0]   dm_hold = '0;
   string         ack_log = "";

   always @(negedge clk) begin
      if (mem_en) begin
         pend     = 1'b1;
         due      = cyc + LAT;
         due_data = mem_f(mem_addr);
         en_cnt++;
         en_cyc   = cyc;
         en_addr  = mem_addr;
         en_wdata = mem_wdata;
         en_we    = mem_we;
         en_busy  = busy;
      end
      if (rst_n) begin
         checks++;
         if (mem_we && !mem_en) begin
            failures++;
            $display("FAIL mem_we_without_en: mem_we=%b mem_en=%b", mem_we, mem_en);
         end
         check32("stall_if", 32'(stall_if), 32'(if_req & ~if_ack));
         check32("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_ack));
         if (if_ack) begin
            ack_log = {ack_log, "I"};
            if (if_sb.size() == 0) check32("if_ack_unexpected", 32'(if_ack), 32'd0);
            else check32("if_rdata", if_rdata, if_sb.pop_front());
         end
         if (dm_ack) begin
            ack_log = {ack_log, "D"};
            if (dm_sb.size() == 0) check32("dm_ack_unexpected", 32'(dm_ack), 32'd0);
            else check32("dm_rdata", dm_rdata, dm_sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Waits for the port ack; lat = cycles from the raise cycle to the ack cycle.
   task automatic wait_ack(input bit is_data, output int lat);
      for (lat = 0; lat < 300; lat++) begin
         @(negedge clk);
         if (is_data ? dm_ack : if_ack) return;
         check32(is_data ? "stall_mem_waiting" : "stall_if_waiting",
                 32'(is_data ? stall_mem : stall_if), 32'd1);
         tick();
      end
      checks++;
      failures++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 300 cycles", is_data ? "dm" : "if");
   endtask

   task automatic req_one(input bit is_data, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input bit drop, output int lat);
      if (is_data) begin
         dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
         if (!we) dm_hold = mem_f(a);
         dm_sb.push_back(dm_hold);
      end else begin
         if_req = 1'b1; if_addr = a;
         if_sb.push_back(mem_f(a));
      end
      wait_ack(is_data, lat);
      tick();
      if (drop) begin
         if (is_data) dm_req = 1'b0;
         else if_req = 1'b0;
      end
   endtask

   task automatic stream(input bit is_data, input int n, input logic [31:0] base);
      int lat;
      for (int i = 0; i < n; i++) req_one(is_data, 1'b0, base + 32'(4 * i), '0, i == n - 1, lat);
   endtask

   typedef struct {
      bit          is_data;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_lat;
      bit          exp_mem_we;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, ld, li, k, e0;
      string exp_order;
      vecs[0] = '{0, 0, 32'h0000_0040, 32'h0,         LAT + 2, 0};
      vecs[1] = '{1, 0, 32'h0000_0100, 32'h0,         LAT + 2, 0};
      vecs[2] = '{1, 1, 32'h0000_0200, 32'hDEAD_BEEF, LAT + 2, 1};
      vecs[3] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         LAT + 2, 0};
      vecs[4] = '{1, 0, 32'h0000_0000, 32'h0,         LAT + 2, 0};
      vecs[5] = '{1, 1, 32'hFFFF_FFFC, 32'h0,         LAT + 2, 1};
      vecs[6] = '{1, 0, 32'h0000_0200, 32'h0,         LAT + 2, 0};
      vecs[7] = '{1, 1, 32'h0000_0010, 32'hFFFF_FFFF, LAT + 2, 1};

      // Reset with random inputs: every output low, stalls follow the requests.
      rst_n = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
         if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
         @(negedge clk);
         check32("rst_if_ack", 32'(if_ack), 0);
         check32("rst_dm_ack", 32'(dm_ack), 0);
         check32("rst_if_rdata", if_rdata, 0);
         check32("rst_dm_rdata", dm_rdata, 0);
         check32("rst_mem_en", 32'(mem_en), 0);
         check32("rst_mem_we", 32'(mem_we), 0);
         check32("rst_mem_addr", mem_addr, 0);
         check32("rst_mem_wdata", mem_wdata, 0);
         check32("rst_busy", 32'(busy), 0);
         check32("rst_stall_if", 32'(stall_if), 32'(if_req));
         check32("rst_stall_mem", 32'(stall_mem), 32'(dm_req));
      end
      tick();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check32("post_rst_busy", 32'(busy), 0);
      tick();

      // Isolated accesses: issue timing, memory port contents, latency.
      for (int i = 0; i < 8; i++) begin
         k  = cyc;
         e0 = en_cnt;
         req_one(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b1, lat);
         check32($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check32($sformatf("v%0d_issue_count", i), 32'(en_cnt - e0), 1);
         check32($sformatf("v%0d_issue_cycle", i), 32'(en_cyc), 32'(k + 1));
         check32($sformatf("v%0d_mem_addr", i), en_addr, vecs[i].addr);
         check32($sformatf("v%0d_mem_we", i), 32'(en_we), 32'(vecs[i].exp_mem_we));
         check32($sformatf("v%0d_busy_at_issue", i), 32'(en_busy), 1);
         if (vecs[i].we) check32($sformatf("v%0d_mem_wdata", i), en_wdata, vecs[i].wdata);
         @(negedge clk);
         check32($sformatf("v%0d_idle_after_ack", i), 32'(busy), 0);
         tick();
      end
      check32("if_rdata_held", if_rdata, mem_f(32'hFFFF_FFFC));
      check32("dm_rdata_after_store", dm_rdata, mem_f(32'h200));

      // Simultaneous fetch and load: data first, fetch after one IDLE cycle.
      fork
         req_one(1'b1, 1'b0, 32'h100, '0, 1'b1, ld);
         req_one(1'b0, 1'b0, 32'h44,  '0, 1'b1, li);
      join
      check32("simul_dm_latency", 32'(ld), 32'(LAT + 2));
      check32("simul_if_latency", 32'(li), 32'(2 * LAT + 5));
      tick();

      // Data held continuously against a waiting fetch.
      ack_log = "";
      fork
         stream(1'b1, 8, 32'h300);
         stream(1'b0, 1, 32'h500);
      join
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_order = "DDDDIDDDD";
`else
      exp_order = "DDDDDDDDI";
`endif
      checks++;
      if (ack_log != exp_order) begin
         failures++;
         $display("FAIL starve_order: got %s expected %s", ack_log, exp_order);
      end
      tick();

      // Reset in the middle of WAIT: access dropped, reissue completes normally.
      if_req = 1'b1; if_addr = 32'h80;
      if_sb.push_back(mem_f(32'h80));
      tick();
      tick();
      rst_n = 1'b0;
      dm_hold = '0;
      #1;
      check32("midrst_mem_en", 32'(mem_en), 0);
      check32("midrst_busy", 32'(busy), 0);
      check32("midrst_if_ack", 32'(if_ack), 0);
      check32("midrst_if_rdata", if_rdata, 0);
      check32("midrst_dm_rdata", dm_rdata, 0);
      check32("midrst_mem_addr", mem_addr, 0);
      check32("midrst_stall_if", 32'(stall_if), 1);
      tick();
      @(negedge clk);
      check32("midrst_no_ack", 32'(if_ack), 0);
      tick();
      rst_n = 1'b1;
      wait_ack(1'b0, lat);
      check32("after_rst_latency", 32'(lat), 32'(LAT + 2));
      tick();
      if_req = 1'b0;
      tick();
      tick();

      check32("if_sb_empty", 32'(if_sb.size()), 0);
      check32("dm_sb_empty", 32'(dm_sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch stage (lw/sw-free path) and the MEM stage (`lw`/`sw`) of the five-stage CPU. It grants one requester at a time, sequences the issue, wait and acknowledge phases of each access, and drives per-port stall outputs to the pipeline. Data accesses have priority over fetches, with an optional anti-starvation guard.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, cycles from the issue cycle to valid `mem_rdata`; must be ≥1.
- `STARVE_MAX`, 4, consecutive data grants allowed while a fetch waits. Used only with the guard compiled in.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle fetch completion.
- `if_rdata`  out  DATA_W  registered fetch data; valid with `if_ack` and held until the next fetch ack.
- `dm_req`  in  1  data request; held stable until `dm_ack`.
- `dm_we`  in  1  1 = store (MemWrite), 0 = load.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_ack`  out  1  one-cycle data completion.
- `dm_rdata`  out  DATA_W  registered load data; unchanged by stores.
- `stall_if`  out  1  `if_req & ~if_ack`.
- `stall_mem`  out  1  `dm_req & ~dm_ack`.
- `mem_en`  out  1  memory access strobe; exactly one cycle per access.
- `mem_we`  out  1  memory write enable; only ever high together with `mem_en`.
- `mem_addr`  out  ADDR_W  registered access address.
- `mem_wdata`  out  DATA_W  registered store data.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:**
  - Sample requests on each edge.
  - If `dm_req` is high, grant data. Otherwise, if `if_req` is high, grant fetch. Otherwise stay in IDLE.
  - On a grant, latch the grant owner, address, write enable and write data, then go to ISSUE.
- **ISSUE (1 cycle):**
  - `mem_en`=1; `mem_we`=`dm_we` for data grants and 0 for fetches.
  - Load the wait counter with `MEM_LAT`-1, then go to WAIT. If `MEM_LAT`=1, skip WAIT and go directly to the capture cycle.
- **WAIT:**
  - Decrement the counter each cycle.
  - In the final WAIT cycle (counter 0), or in the ISSUE+1 cycle when `MEM_LAT`=1, `mem_rdata` is valid. For a load or fetch, capture it into the owner's rdata register at the end of that cycle. Then go to ACK.
- **ACK (1 cycle):**
  - Assert the owner's ack, then go to IDLE.
  - Requests are not sampled in ACK, so the acked requester is never re-granted on its stale request.
- IDLE therefore lasts at least one cycle between accesses.
- Stores follow the same latency as loads; `dm_rdata` is not updated.
- `stall_if` and `stall_mem` are combinational from req/ack. `busy` is registered state decode.
- **Reset (any state, including mid-access):**
  - State → IDLE; counters and starve count → 0.
  - Every output is 0: `if_ack`, `dm_ack`, `if_rdata`, `dm_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`. `stall_if`/`stall_mem` follow their req inputs.
  - The aborted access is dropped with no ack. The requester reissues after reset.

## Timing
- Request first sampled high at the edge ending cycle k, in IDLE.
- Issue (`mem_en`) occurs in cycle k+1.
- `mem_rdata` is valid in cycle k+1+`MEM_LAT`.
- Ack occurs in cycle k+2+`MEM_LAT`.
- Earliest next issue is cycle k+4+`MEM_LAT`.
- Request-to-ack latency is `MEM_LAT`+2 cycles. Throughput is one access per `MEM_LAT`+3 cycles.
- A request arriving while the FSM is busy waits; the waiting port's stall output stays high.
- A requester that drops req before ack violates the protocol; the result is undefined.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A saturating counter increments on each data grant made while `if_req` is high.
  - When the count equals `STARVE_MAX` and `if_req` is high, the next IDLE arbitration grants the fetch even if `dm_req` is high.
  - Any fetch grant clears the count.
- Undefined: strict data priority; the counter is not built and `STARVE_MAX` is ignored.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs 0, `busy`=0. Release → IDLE, `busy`=0.
- **Single fetch, `MEM_LAT`=2:** `if_req` with `if_addr`=0x40 from cycle 1; memory returns 0x8C220004 → `mem_en`=1 and `mem_addr`=0x40 in cycle 2 only; `if_ack`=1 in cycle 5 with `if_rdata`=0x8C220004; `stall_if` high in cycles 1–4.
- **Simultaneous requests:** `if_req` (0x44) and load `dm_req` (0x100) in cycle 1 → data issued in cycle 2, `dm_ack` in cycle 5; fetch issued in cycle 7, `if_ack` in cycle 10.
- **Store:** `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF → `mem_en`=`mem_we`=1 for one cycle with those values; `dm_ack` after 4 cycles; `dm_rdata` unchanged.
- **Starvation, `STARVE_MAX`=4:** `dm_req` and `if_req` held continuously → with the guard, 4 data acks, then `if_ack`, then data resumes; without the guard, `if_ack` never asserts.
- **Reset during WAIT:** pulse `rst_n` low mid-access → no ack, `mem_en`=0; a new fetch after release completes with normal latency.
